display_scan: RTL and testbench
===============================

# display_scan

Multiplexed 7-segment display driver that consumes the operand and sum nibbles produced by the 4-bit adder path and scans them onto a common-segment display. A synchronous modulo-DIGITS scan counter replaces ad-hoc ripple sequencing on the reader side of the digit-select interface. New display data is accepted through a Load/Ready handshake and applied only at frame boundaries, so a frame never mixes old and new values.

## Interface
- DIGITS, 6: number of multiplexed digits, range 2..8.
- DIV, 50000: Clk cycles per digit slot. Must be at least BLANK+2.
- BLANK, 500: Clk cycles at the start of each slot with all digits off (anti-ghosting). Must be less than DIV-1.
- Clk  in  1  single clock, rising edge.
- Clr_n  in  1  asynchronous active-low reset.
- Load  in  1  request to capture Data/Dp.
- Ready  out  1  high when a new Load will be accepted.
- Data  in  4*DIGITS  hex nibbles; nibble i at [4i+3:4i] drives digit i.
- Dp  in  DIGITS  decimal point per digit, active-high.
- Seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- Dig  out  DIGITS  digit enables, active-low, one-hot-low when lit.
- Idx  out  3  current scan index, 0..DIGITS-1.

## Operation
- Prescaler `pre` counts 0..DIV-1 and wraps. `tick` is asserted when pre==DIV-1.
- On tick: Idx = (Idx==DIGITS-1) ? 0 : Idx+1. `wrap` is tick with Idx==DIGITS-1. Idx never leaves 0..DIGITS-1 and has no intermediate glitch states.
- Slot phase: BLANK while pre<BLANK, SHOW otherwise.
  - BLANK: Dig = all 1, Seg = 8'hFF.
  - SHOW: Dig[Idx]=0 and all other Dig bits 1.
  - SHOW: Seg = {~dp, hex7(nibble[Idx])} when `valid`, else 8'hFF.
- hex7 uses the standard glyphs 0-9, A, b, C, d, E, F.
  - 0 is 7'b1000000, 8 is 7'b0000000, F is 7'b0001110 (gfedcba, active-low).
- Handshake:
  - Load && Ready captures Data/Dp into the shadow register, sets `pending`, and drops Ready.
  - Load while Ready=0 is ignored; it is neither queued nor an error.
- Transfer: on a wrap edge with pending=1 at the start of that cycle:
  - shadow moves to the display register;
  - valid is set to 1;
  - pending is cleared and Ready returns to 1.
- Load accepted in the same cycle as a wrap: captured to shadow, transferred at the next wrap, not this one.
- Reset values (asynchronous, while Clr_n=0):
  - pre=0, Idx=0, Ready=1, pending=0, valid=0;
  - shadow and display registers = 0;
  - Seg=8'hFF, Dig=all 1.
- Reset mid-frame or mid-handshake: pending data is discarded and the display blanks immediately.
- After Clr_n rises, scanning restarts at slot 0 BLANK phase.

## Timing
- Seg, Dig, Ready and Idx are registered; no combinational path from any input to any output.
- Seg/Dig reflect pre/Idx one cycle later. The first lit cycle of a slot is the edge after pre reaches BLANK.
- Load-to-Ready-low latency: 1 edge.
- Ready-high recovery: on the wrap edge, between 1 and DIGITS*DIV cycles after acceptance.
- New data first appears in digit 0 of the frame following the transfer.
- Frame period: DIGITS*DIV cycles.
- Every digit is lit for exactly DIV-BLANK cycles per frame.

## Structure
- Package `display_pkg`: function hex7(nibble) returning 7 bits, SEG_OFF=8'hFF, and a phase enum {PH_BLANK, PH_SHOW}.
- One sub-module is natural: `scan_timer`, which holds pre, tick, Idx and wrap with DIV/DIGITS parameters.
- The top level holds the handshake, shadow/display registers and output registers.

## Test plan
All scenarios run with DIGITS=6, DIV=4, BLANK=1.
- Reset: hold Clr_n=0 for 3 cycles, release.
  - During reset: Seg=FF, Dig=6'h3F, Ready=1, Idx=0.
  - Over 24 cycles: all digits stay dark because valid=0.
  - Idx sequence is 0,1,2,3,4,5,0, each value held 4 cycles.
- Load Data=24'h012345, Dp=6'b000001 at cycle 2.
  - Ready drops next edge and rises at the wrap edge.
  - Next frame, Idx=0: Dig=6'b111110, Seg={0,7'b0010010} (digit "5" with dp on).
- Load while Ready=0 with Data=24'hFFFFFF: ignored.
  - The frame after transfer shows the first data, not FFFFFF.
- Load in the wrap cycle: Ready stays 0 for a full 24-cycle frame.
  - The transfer lands on the following wrap.
- Blanking: in every slot, the cycle after pre==0 has Dig=6'h3F.
  - The next 3 cycles have exactly one Dig bit low.
- Reset asserted while pending=1: outputs blank immediately.
  - After release: Ready=1, the old shadow data is never displayed, and the display stays dark until a new Load is transferred.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
//   SEG_OFF : segment bus value with every segment and the dp dark (active-low)
//   phase_e : blank/show phase of a digit slot
//   hex7    : nibble to gfedcba glyph, active-low, hex glyphs 0-9 A b C d E F
package display_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        logic [6:0] g;
        g = 7'b1111111;
        case (nibble)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timing for the digit scanner: a prescaler that wraps every DIV cycles
// and a synchronous modulo-DIGITS slot index advanced on the prescaler tick.
//   clk_sys : clock
//   rst_b   : asynchronous active-low reset
//   idx     : current slot index, 0..DIGITS-1 (registered)
//   wrap    : last cycle of the last slot of a frame
//   phase   : blank/show phase of the current slot, derived from the prescaler
//
// phase    | meaning
// PH_BLANK | first BLANK cycles of a slot, all digits off
// PH_SHOW  | remainder of the slot, digit idx lit
module scan_timer
    import display_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int DIV    = 50000,
    parameter int BLANK  = 500
) (
    input  logic       clk_sys,
    input  logic       rst_b,
    output logic [2:0] idx,
    output logic       wrap,
    output phase_e     phase
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic             tick;

    always_comb begin
        tick  = (pre_q == PRE_W'(DIV - 1));
        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            // Explicit compare rather than a power-of-two rollover so the
            // index never visits values past DIGITS-1.
            idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        wrap  = tick && (idx_q == 3'(DIGITS - 1));
        phase = (pre_q < PRE_W'(BLANK)) ? PH_BLANK : PH_SHOW;
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/display_scan.sv
// Multiplexed common-segment 7-segment driver. New digit data is taken through
// a Load/Ready handshake into a shadow register and copied to the display
// register only on the frame wrap, so a frame never mixes old and new data.
//   Clk   : clock
//   Clr_n : asynchronous active-low reset
//   Load  : capture request for Data/Dp, honoured only while Ready=1
//   Ready : a Load will be accepted this cycle
//   Data  : nibble i at [4i+3:4i] drives digit i
//   Dp    : decimal point per digit, active-high
//   Seg   : {dp,g,f,e,d,c,b,a}, active-low
//   Dig   : digit enables, active-low
//   Idx   : current scan slot
module display_scan
    import display_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int DIV    = 50000,
    parameter int BLANK  = 500
) (
    input  logic                  Clk,
    input  logic                  Clr_n,
    input  logic                  Load,
    output logic                  Ready,
    input  logic [4*DIGITS-1:0]   Data,
    input  logic [DIGITS-1:0]     Dp,
    output logic [7:0]            Seg,
    output logic [DIGITS-1:0]     Dig,
    output logic [2:0]            Idx
);

    logic [2:0] idx;
    logic       wrap;
    phase_e     phase;

    scan_timer #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .BLANK  (BLANK)
    ) u_timer (
        .clk_sys (Clk),
        .rst_b   (Clr_n),
        .idx     (idx),
        .wrap    (wrap),
        .phase   (phase)
    );

    // ready_q low means the shadow register holds data awaiting transfer.
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     dig_q, dig_d;
    logic                  accept;
    logic                  transfer;
    logic [3:0]            nibble;
    logic                  dp_bit;

    always_comb begin
        accept      = Load && ready_q;
        transfer    = wrap && !ready_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;

        // transfer and accept are mutually exclusive: both depend on ready_q
        // with opposite polarity, so a Load landing on the wrap edge is only
        // captured and waits for the next wrap.
        if (transfer) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            valid_d   = 1'b1;
            ready_d   = 1'b1;
        end
        if (accept) begin
            shadow_d    = Data;
            shadow_dp_d = Dp;
            ready_d     = 1'b0;
        end

        nibble = disp_q[{idx, 2'b00} +: 4];
        dp_bit = disp_dp_q[idx];
        seg_d  = SEG_OFF;
        dig_d  = '1;
        if (phase == PH_SHOW) begin
            dig_d[idx] = 1'b0;
            if (valid_q) begin
                seg_d = {~dp_bit, hex7(nibble)};
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            seg_q       <= SEG_OFF;
            dig_q       <= '1;
        end else begin
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
        end
    end

    assign Ready = ready_q;
    assign Seg   = seg_q;
    assign Dig   = dig_q;
    assign Idx   = idx;

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

    localparam int DIGITS = 6;
    localparam int DIV    = 4;
    localparam int BLANK  = 1;
    localparam int FRAME  = DIGITS * DIV;

    logic                  clk   = 1'b0;
    logic                  clr_n = 1'b1;
    logic                  load  = 1'b0;
    logic [4*DIGITS-1:0]   data  = '0;
    logic [DIGITS-1:0]     dp    = '0;
    logic                  ready;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     dig;
    logic [2:0]            idx;

    always #5 clk = ~clk;

    display_scan #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .BLANK  (BLANK)
    ) dut (
        .Clk   (clk),
        .Clr_n (clr_n),
        .Load  (load),
        .Ready (ready),
        .Data  (data),
        .Dp    (dp),
        .Seg   (seg),
        .Dig   (dig),
        .Idx   (idx)
    );

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [7:0] seg;
    } vec_t;
    vec_t vecs[16];

    typedef struct {
        logic [7:0]        seg;
        logic [DIGITS-1:0] dig;
        logic [2:0]        idx;
        logic              ready;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int                  m_k;
    bit                  m_ready, m_pending, m_valid;
    logic [4*DIGITS-1:0] m_shadow, m_disp;
    logic [DIGITS-1:0]   m_shadow_dp, m_disp_dp;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_k = 0; m_ready = 1; m_pending = 0; m_valid = 0;
        m_shadow = '0; m_disp = '0; m_shadow_dp = '0; m_disp_dp = '0;
    endfunction

    // Predicts the outputs after the coming edge from the cycle count since
    // reset release and the bench's own handshake state.
    function automatic void model_push();
        exp_t       e;
        int         pre, slot;
        bit         wrap, acc, xfer;
        logic [3:0] nib;
        pre  = m_k % DIV;
        slot = (m_k / DIV) % DIGITS;
        e.seg = 8'hFF;
        e.dig = '1;
        if (pre >= BLANK) begin
            e.dig = ~(DIGITS'(1) << slot);
            if (m_valid) begin
                nib   = m_disp[4*slot +: 4];
                e.seg = {~m_disp_dp[slot], vecs[nib].seg[6:0]};
            end
        end
        wrap = (m_k % FRAME) == FRAME - 1;
        acc  = load && m_ready;
        xfer = wrap && m_pending;
        if (xfer) begin
            m_disp = m_shadow; m_disp_dp = m_shadow_dp;
            m_valid = 1; m_pending = 0; m_ready = 1;
        end
        if (acc) begin
            m_shadow = data; m_shadow_dp = dp;
            m_pending = 1; m_ready = 0;
        end
        m_k++;
        e.idx   = 3'((m_k / DIV) % DIGITS);
        e.ready = m_ready;
        sb.push_back(e);
    endfunction

    task automatic step();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_seg", seg, e.seg);
        chk("sb_dig", dig, e.dig);
        chk("sb_idx", idx, e.idx);
        chk("sb_ready", ready, e.ready);
    endtask

    task automatic do_reset(int n);
        load  = 1'b0;
        clr_n = 1'b0;
        #1;
        chk("rst_seg", seg, 8'hFF);
        chk("rst_dig", dig, 6'h3F);
        chk("rst_ready", ready, 1);
        chk("rst_idx", idx, 0);
        repeat (n) @(posedge clk);
        #1;
        chk("rst_hold_seg", seg, 8'hFF);
        chk("rst_hold_idx", idx, 0);
        clr_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idxlog[FRAME];
        int n, dark, changes;
        int lit[DIGITS];

        vecs[0]  = '{4'h0, 1'b0, 8'hC0};
        vecs[1]  = '{4'h1, 1'b1, 8'h79};
        vecs[2]  = '{4'h2, 1'b0, 8'hA4};
        vecs[3]  = '{4'h3, 1'b1, 8'h30};
        vecs[4]  = '{4'h4, 1'b0, 8'h99};
        vecs[5]  = '{4'h5, 1'b1, 8'h12};
        vecs[6]  = '{4'h6, 1'b0, 8'h82};
        vecs[7]  = '{4'h7, 1'b1, 8'h78};
        vecs[8]  = '{4'h8, 1'b0, 8'h80};
        vecs[9]  = '{4'h9, 1'b1, 8'h10};
        vecs[10] = '{4'hA, 1'b0, 8'h88};
        vecs[11] = '{4'hB, 1'b1, 8'h03};
        vecs[12] = '{4'hC, 1'b0, 8'hC6};
        vecs[13] = '{4'hD, 1'b1, 8'h21};
        vecs[14] = '{4'hE, 1'b0, 8'h86};
        vecs[15] = '{4'hF, 1'b1, 8'h0E};
        model_reset();

        // Reset, then one dark frame with the slot index sequence.
        #2;
        do_reset(3);
        dark = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (seg !== 8'hFF) dark++;
            idxlog[i] = int'(idx);
        end
        chk("dark_frame", dark, 0);
        chk("idx_edge3", idxlog[2], 0);
        chk("idx_edge4", idxlog[3], 1);
        chk("idx_edge20", idxlog[19], 5);
        chk("idx_edge24", idxlog[23], 0);
        changes = (idxlog[0] != 0) ? 1 : 0;
        for (int i = 1; i < FRAME; i++) if (idxlog[i] != idxlog[i-1]) changes++;
        chk("idx_changes", changes, 6);

        // Load at cycle 2 of a frame; a second Load while busy is ignored.
        step(); step();
        load = 1'b1; data = 24'h012345; dp = 6'b000001;
        step();
        load = 1'b0;
        chk("ready_drop", ready, 0);
        n = 0;
        repeat (5) begin step(); n++; end
        load = 1'b1; data = 24'hFFFFFF; dp = 6'h3F;
        step(); n++;
        load = 1'b0;
        chk("ignored_load_ready", ready, 0);
        while (ready !== 1'b1 && n < 40) begin step(); n++; end
        chk("ready_recover", n, 21);
        step();
        chk("frame_blank_dig", dig, 6'h3F);
        step();
        chk("digit0_dig", dig, 6'b111110);
        chk("digit0_seg", seg, 8'h12);
        repeat (4) step();
        chk("digit1_dig", dig, 6'b111101);
        chk("digit1_seg", seg, 8'h99);

        // Load accepted on the wrap edge waits a whole frame.
        while ((m_k % FRAME) != FRAME - 1) step();
        load = 1'b1; data = 24'hABCDEF; dp = 6'b100000;
        step();
        load = 1'b0;
        chk("wrap_load_ready", ready, 0);
        n = 0;
        while (ready !== 1'b1 && n < 40) begin step(); n++; end
        chk("wrap_load_frame", n, 24);
        step(); step();
        chk("wrap_load_seg", seg, 8'h8E);

        // Blanking and one-hot digit per slot over a full frame.
        while ((m_k % FRAME) != 0) step();
        for (int d = 0; d < DIGITS; d++) lit[d] = 0;
        for (int s = 0; s < DIGITS; s++) begin
            step();
            chk("blank_slot", dig, 6'h3F);
            for (int j = 0; j < DIV - 1; j++) begin
                step();
                chk("one_hot", $countones(~dig), 1);
                for (int d = 0; d < DIGITS; d++) if (!dig[d]) lit[d]++;
            end
        end
        for (int d = 0; d < DIGITS; d++) chk("lit_cycles", lit[d], DIV - BLANK);

        // Reset while pending discards the shadow data.
        load = 1'b1; data = 24'h777777; dp = 6'h00;
        step();
        load = 1'b0;
        chk("pend_ready", ready, 0);
        step(); step();
        do_reset(3);
        chk("ready_after_rst", ready, 1);
        dark = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (seg !== 8'hFF) dark++;
        end
        chk("dark_after_rst", dark, 0);

        // Glyph table: every nibble with alternating decimal point.
        for (int v = 0; v < 16; v++) begin
            data = {DIGITS{vecs[v].nib}};
            dp   = {DIGITS{vecs[v].dp}};
            load = 1'b1;
            step();
            load = 1'b0;
            n = 0;
            while (ready !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
            chk("xfer_in_bound", n < 2 * FRAME, 1);
            while (!((m_k % DIV) == BLANK && ((m_k / DIV) % DIGITS) == 0)) step();
            step();
            chk("glyph_seg", seg, vecs[v].seg);
            chk("glyph_dig", dig, 6'b111110);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
